// File: rtl/trojan_activity_monitor.sv
// Runtime Trojan activity monitor: trigger-pattern hits and victim
// mismatches feed saturating counters and a windowed alarm FSM.
module trojan_activity_monitor #(
    parameter int unsigned N_TRIG   = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ALARM_TH = 4,
    parameter int unsigned WIN_LEN  = 16
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              EN,
    input  logic              CLR,
    input  logic [N_TRIG-1:0] TRIG_NETS,
    input  logic [N_TRIG-1:0] RARE_PAT,
    input  logic              VICTIM_OBS,
    input  logic              VICTIM_REF,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  MISM_CNT,
    output logic [1:0]        STATE,
    output logic              ALARM
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SUSPECT = 2'd2,
        ALARMED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W:0]   TH       = (CNT_W+1)'(ALARM_TH);

    logic [N_TRIG-1:0] trig_q;
    logic              obs_q;
    logic              ref_q;
    logic              v_q;

    logic              hit;
    logic              mism;
    logic [CNT_W:0]    whit_sum;
    logic [CNT_W-1:0]  win_inc;

    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  mism_cnt;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  win;
    logic [CNT_W-1:0]  win_n;
    logic [CNT_W-1:0]  whit;
    logic [CNT_W-1:0]  whit_n;

    assign hit      = v_q & (trig_q == RARE_PAT);
    assign mism     = v_q & (obs_q != ref_q);
    assign whit_sum = {1'b0, whit} + (CNT_W+1)'(hit);
    assign win_inc  = win + ONE;

    // Input capture; a clear also drops the pending sample.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            trig_q <= '0;
            obs_q  <= 1'b0;
            ref_q  <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            trig_q <= TRIG_NETS;
            obs_q  <= VICTIM_OBS;
            ref_q  <= VICTIM_REF;
            v_q    <= EN & ~CLR;
        end
    end

    // Saturating event counters, active in every state.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            hit_cnt  <= '0;
            mism_cnt <= '0;
        end else if (CLR) begin
            hit_cnt  <= '0;
            mism_cnt <= '0;
        end else begin
            if (hit && hit_cnt != CNT_MAX)
                hit_cnt <= hit_cnt + ONE;
            if (mism && mism_cnt != CNT_MAX)
                mism_cnt <= mism_cnt + ONE;
        end
    end

    // FSM state plus window bookkeeping registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            win   <= '0;
            whit  <= '0;
        end else begin
            state <= state_n;
            win   <= win_n;
            whit  <= whit_n;
        end
    end

    // Next-state: arm on first valid sample, open a window on a hit,
    // alarm on corrupted hit or threshold, re-arm when the window ends.
    always_comb begin
        state_n = state;
        win_n   = win;
        whit_n  = whit;
        if (CLR) begin
            state_n = IDLE;
            win_n   = '0;
            whit_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (v_q)
                        state_n = ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        state_n = (ALARM_TH <= 1) ? ALARMED : SUSPECT;
                        win_n   = '0;
                        whit_n  = ONE;
                    end
                end
                SUSPECT: begin
                    if (v_q) begin
                        win_n  = win_inc;
                        whit_n = whit_sum[CNT_W-1:0];
                        if (hit && mism) begin
                            state_n = ALARMED;
                        end else if (whit_sum >= TH) begin
                            state_n = ALARMED;
                        end else if (win_inc == WIN_LAST) begin
                            state_n = ARMED;
                            win_n   = '0;
                            whit_n  = '0;
                        end
                    end
                end
                ALARMED: begin
                    state_n = ALARMED;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign HIT_CNT  = hit_cnt;
    assign MISM_CNT = mism_cnt;
    assign STATE    = state;
    assign ALARM    = (state == ALARMED);

endmodule

// File: tb/tb_trojan_activity_monitor.sv
// Directed scoreboard bench for trojan_activity_monitor.
// Expectations are queued at drive time and checked two edges later.
module tb_trojan_activity_monitor;

    logic       CK;
    logic       RN;
    logic       EN;
    logic       CLR;
    logic [7:0] TRIG_NETS;
    logic [7:0] RARE_PAT;
    logic       VICTIM_OBS;
    logic       VICTIM_REF;
    logic [7:0] HIT_CNT;
    logic [7:0] MISM_CNT;
    logic [1:0] STATE;
    logic       ALARM;

    trojan_activity_monitor #(
        .N_TRIG(8), .CNT_W(8), .ALARM_TH(4), .WIN_LEN(16)
    ) dut (
        .CK(CK), .RN(RN), .EN(EN), .CLR(CLR),
        .TRIG_NETS(TRIG_NETS), .RARE_PAT(RARE_PAT),
        .VICTIM_OBS(VICTIM_OBS), .VICTIM_REF(VICTIM_REF),
        .HIT_CNT(HIT_CNT), .MISM_CNT(MISM_CNT),
        .STATE(STATE), .ALARM(ALARM)
    );

    typedef struct {
        int         due;
        logic [1:0] st;
        logic       al;
        logic [7:0] hc;
        logic [7:0] mc;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   hc_e   = 0;
    int   mc_e   = 0;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Scoreboard: pop expectations that fall due after this edge.
    always begin
        exp_t e;
        @(posedge CK);
        cyc = cyc + 1;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            assert ({STATE, ALARM, HIT_CNT, MISM_CNT} ===
                    {e.st, e.al, e.hc, e.mc})
            else begin
                errors++;
                $error("FAIL %s got st=%0d al=%0d hc=%0d mc=%0d exp st=%0d al=%0d hc=%0d mc=%0d",
                       e.tag, STATE, ALARM, HIT_CNT, MISM_CNT,
                       e.st, e.al, e.hc, e.mc);
            end
        end
    end

    task automatic step(input logic en, input logic [7:0] trig,
                        input logic obs, input logic rf,
                        input logic clr, input logic [1:0] st,
                        input string tag);
        exp_t e;
        exp_t t;
        @(negedge CK);
        EN         = en;
        TRIG_NETS  = trig;
        VICTIM_OBS = obs;
        VICTIM_REF = rf;
        CLR        = clr;
        if (clr) begin
            hc_e = 0;
            mc_e = 0;
            if (q.size() > 0 && q[q.size()-1].due == cyc + 1) begin
                t    = q[q.size()-1];
                t.st = 2'd0;
                t.al = 1'b0;
                t.hc = 8'd0;
                t.mc = 8'd0;
                q[q.size()-1] = t;
            end
        end else if (en) begin
            if (trig == RARE_PAT && hc_e < 255) hc_e++;
            if (obs != rf && mc_e < 255) mc_e++;
        end
        e.due = cyc + 2;
        e.st  = st;
        e.al  = (st == 2'd3);
        e.hc  = 8'(hc_e);
        e.mc  = 8'(mc_e);
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic chk0(input string tag);
        checks++;
        assert ({STATE, ALARM, HIT_CNT, MISM_CNT} === 19'd0)
        else begin
            errors++;
            $error("FAIL %s got st=%0d al=%0d hc=%0d mc=%0d exp all zero",
                   tag, STATE, ALARM, HIT_CNT, MISM_CNT);
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge CK);
        #2;
    endtask

    initial begin
        RN         = 1'b0;
        EN         = 1'b0;
        CLR        = 1'b0;
        TRIG_NETS  = 8'h00;
        RARE_PAT   = 8'hFF;
        VICTIM_OBS = 1'b0;
        VICTIM_REF = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        chk0("reset");
        @(negedge CK);
        RN = 1'b1;

        // Idle with EN low
        for (int i = 0; i < 10; i++)
            step(0, 8'h00, 0, 0, 0, 2'd0, "idle");

        // Single hit, window expiry with a frozen gap
        step(1, 8'h00, 0, 0, 0, 2'd1, "arm");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "win_open");
        for (int i = 1; i <= 15; i++) begin
            step(1, 8'h00, 0, 0, 0, (i == 15) ? 2'd1 : 2'd2, "win_run");
            if (i == 7) begin
                step(0, 8'hFF, 1, 0, 0, 2'd2, "win_frozen");
                step(0, 8'hFF, 1, 0, 0, 2'd2, "win_frozen");
            end
        end
        step(0, 8'h00, 0, 0, 0, 2'd1, "pre_clr1");
        step(0, 8'h00, 0, 0, 1, 2'd0, "clr1");

        // Threshold alarm, then counters keep running while alarmed
        step(1, 8'h00, 0, 0, 0, 2'd1, "th_arm");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "th_hit1");
        step(1, 8'h00, 0, 0, 0, 2'd2, "th_gap1");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "th_hit2");
        step(1, 8'h00, 0, 0, 0, 2'd2, "th_gap2");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "th_hit3");
        step(1, 8'hFF, 0, 0, 0, 2'd3, "th_hit4");
        step(1, 8'h00, 1, 0, 0, 2'd3, "alarm_mism");
        step(1, 8'hFF, 0, 0, 0, 2'd3, "alarm_hit");
        step(0, 8'h00, 0, 0, 0, 2'd3, "pre_clr2");
        step(0, 8'h00, 0, 0, 1, 2'd0, "clr2");

        // Hit plus corruption inside a window
        step(1, 8'h00, 0, 0, 0, 2'd1, "hc_arm");
        step(1, 8'h00, 1, 0, 0, 2'd1, "armed_mism");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "hc_open");
        step(1, 8'hFF, 1, 0, 0, 2'd3, "hit_corrupt");
        step(0, 8'h00, 0, 0, 0, 2'd3, "pre_clr3");
        step(0, 8'h00, 0, 0, 1, 2'd0, "clr3");

        // Mismatch counter saturation
        for (int i = 0; i < 300; i++)
            step(1, 8'h0F, 1, 0, 0, 2'd1, "sat");
        step(0, 8'h00, 0, 0, 0, 2'd1, "sat_hold");
        step(0, 8'h00, 0, 0, 1, 2'd0, "clr4");

        // Build whit=2 then async reset between edges
        step(1, 8'h00, 0, 0, 0, 2'd1, "ar_arm");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "ar_hit1");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "ar_hit2");
        step(0, 8'h00, 0, 0, 0, 2'd2, "ar_hold");
        drain();
        @(posedge CK);
        #3;
        RN = 1'b0;
        #1;
        chk0("async_reset");
        hc_e = 0;
        mc_e = 0;
        #3;
        RN = 1'b1;

        // Window restarts from scratch: three hits stay below threshold
        step(1, 8'h00, 0, 0, 0, 2'd1, "re_arm");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "re_hit1");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "re_hit2");
        step(1, 8'hFF, 0, 0, 0, 2'd2, "re_hit3");
        step(1, 8'h00, 0, 0, 0, 2'd2, "re_quiet");
        step(0, 8'h00, 0, 0, 0, 2'd2, "re_end");
        drain();

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trojan_activity_monitor.md
Name: trojan_activity_monitor

Overview:
- Runtime monitor placed directly downstream of a trigger-instrumented benchmark netlist (s27-class, 8 trigger nets plus one payload victim net).
- Watches the candidate trigger nets for the rare activation pattern.
- Compares the observed victim net against a golden reference copy.
- Raises a sticky ALARM when activation plus corruption evidence accumulates inside a bounded window.

Parameters:
- N_TRIG, 8: number of monitored trigger nets.
- CNT_W, 8: width of the saturating event counters.
- ALARM_TH, 4: pattern hits inside one window that force ALARM.
- WIN_LEN, 16: window length in valid cycles; legal range 2..2^CNT_W.

Ports:
- CK  in  1: clock; all state updates on the rising edge.
- RN  in  1: asynchronous active-low reset.
- EN  in  1: sample-valid qualifier for this cycle's inputs.
- CLR  in  1: synchronous clear of counters and FSM.
- TRIG_NETS  in  N_TRIG: live values of the candidate trigger nets.
- RARE_PAT  in  N_TRIG: activation pattern to match; static while EN=1.
- VICTIM_OBS  in  1: victim net as seen after the payload gate.
- VICTIM_REF  in  1: golden (Trojan-free) value of the victim net.
- HIT_CNT  out  CNT_W: total pattern hits, saturating.
- MISM_CNT  out  CNT_W: total victim mismatches, saturating.
- STATE  out  2: FSM state, encoded IDLE=0, ARMED=1, SUSPECT=2, ALARMED=3.
- ALARM  out  1: high exactly when STATE=ALARMED.

Behaviour:
- Reset (RN=0, asynchronous): all registers cleared.
  - HIT_CNT=0, MISM_CNT=0, STATE=IDLE, ALARM=0.
  - Internal window counter win=0 and window hit count whit=0.
- Input stage: on each edge, register trig_q<=TRIG_NETS, obs_q<=VICTIM_OBS, ref_q<=VICTIM_REF, v_q<=EN.
- Event definitions:
  - hit = v_q & (trig_q==RARE_PAT).
  - mism = v_q & (obs_q!=ref_q).
- Latency: inputs presented in cycle n are captured at edge n. HIT_CNT, MISM_CNT, STATE and ALARM reflect them after edge n+1.
- Counters:
  - HIT_CNT increments by 1 on hit; MISM_CNT increments by 1 on mism.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Counters update in every state, including ALARMED.
- CLR takes priority over all other updates. At the next edge: counters=0, win=0, whit=0, STATE=IDLE, ALARM=0, and v_q is forced to 0.
- FSM transitions, evaluated only when CLR=0:
  - IDLE: v_q=1 -> ARMED. A hit in that same cycle is counted in HIT_CNT but does not open a window.
  - ARMED: hit -> SUSPECT with win=0 and whit=1. If ALARM_TH=1, the hit goes directly to ALARMED.
  - SUSPECT: on each v_q=1 cycle, win increments and whit increments on hit. Exits are evaluated in this order:
    1. hit & mism in the same cycle -> ALARMED.
    2. whit+hit >= ALARM_TH -> ALARMED.
    3. win == WIN_LEN-1 -> ARMED, with win and whit cleared.
    4. Otherwise stay in SUSPECT.
  - SUSPECT with v_q=0: state, win and whit are all frozen.
  - ALARMED: sticky. Leaves only via CLR or RN.
- A mism outside SUSPECT only increments MISM_CNT; it never causes a state change.
- Reset asserted mid-window: immediate return to the reset values above; no partial window is retained.
- EN deasserted: no events are counted and the FSM holds, except for the IDLE->ARMED transition, which requires v_q=1.

Test Plan:
- Reset then idle: RN low 2 cycles, EN=0 for 10 cycles -> STATE=0, ALARM=0, HIT_CNT=0, MISM_CNT=0 throughout.
- Single hit, window expiry: RARE_PAT=8'hFF, EN=1, TRIG_NETS=8'hFF for 1 cycle then 8'h00 -> STATE 1->2, returns to 1 after 15 further valid cycles, HIT_CNT=1, ALARM=0.
- Threshold alarm: 4 hits within 16 valid cycles, VICTIM_OBS==VICTIM_REF -> ALARM=1 two edges after the 4th hit is presented, HIT_CNT=4, MISM_CNT=0.
- Hit with corruption: in SUSPECT, present a hit with VICTIM_OBS=1, VICTIM_REF=0 -> ALARM=1 next edge after capture, MISM_CNT=1.
- Saturation and clear: 300 consecutive mismatches with CNT_W=8 -> MISM_CNT=255, with no wrap. Then CLR=1 for 1 cycle -> MISM_CNT=0, STATE=0, ALARM=0.
- Async reset mid-window: in SUSPECT with whit=2, pulse RN low between edges -> outputs reset immediately without waiting for CK. A later single hit does not alarm (whit restarts at 1).
